// File: rtl/mij_sched_ctrl.sv
// Phase sequencer for the QC-LDPC M_ij message memory: LLR load, read/process/write-back
// iterations, hard-decision flush, done. Optional macro: SYNDROME_EARLY_EXIT_EN.
`timescale 1ns/1ps

module mij_sched_ctrl #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int MAX_ITER = 8,
  parameter int PROC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              llr_valid,
  output logic              llr_ready,
  input  logic              syndrome_ok,
  output logic              mem_init,
  output logic              mem_re,
  output logic              mem_we,
  output logic              mem_done,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        iter_cnt,
  output logic              busy,
  output logic              dec_done
);

  localparam int LAT_W = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    WAIT,
    WRITE,
    CHECK,
    FLUSH,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   wcnt, wcnt_nxt;
  logic [LAT_W-1:0]  lat, lat_nxt;
  logic [7:0]        iter_nxt;
  logic [8:0]        iter_inc;
  logic              init_nxt;
  logic              exit_now;

  assign iter_inc = {1'b0, iter_cnt} + 9'd1;

`ifdef SYNDROME_EARLY_EXIT_EN
  assign exit_now = (iter_inc == 9'(MAX_ITER)) || syndrome_ok;
`else
  logic unused_syndrome;
  assign unused_syndrome = syndrome_ok;
  assign exit_now = (iter_inc == 9'(MAX_ITER));
`endif

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wcnt_nxt  = wcnt;
    lat_nxt   = lat;
    iter_nxt  = iter_cnt;
    init_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          addr_nxt  = '0;
          wcnt_nxt  = '0;
          iter_nxt  = 8'd0;
        end
      end
      // wcnt counts accepted words; the extra cycle at wcnt==DEPTH shows the last mem_init
      LOAD: begin
        if (wcnt == (ADDR_W+1)'(DEPTH)) begin
          state_nxt = READ;
          addr_nxt  = '0;
        end else begin
          addr_nxt = wcnt[ADDR_W-1:0];
          if (llr_valid) begin
            init_nxt = 1'b1;
            wcnt_nxt = wcnt + (ADDR_W+1)'(1);
          end
        end
      end
      READ: begin
        state_nxt = WAIT;
        lat_nxt   = '0;
      end
      WAIT: begin
        if (lat == LAT_W'(PROC_LAT - 1)) begin
          state_nxt = WRITE;
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end
      WRITE: begin
        if (addr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = CHECK;
          addr_nxt  = '0;
        end else begin
          state_nxt = READ;
          addr_nxt  = addr + ADDR_W'(1);
        end
      end
      CHECK: begin
        iter_nxt  = (iter_cnt == 8'hFF) ? iter_cnt : iter_inc[7:0];
        addr_nxt  = '0;
        state_nxt = exit_now ? FLUSH : READ;
      end
      FLUSH: begin
        if (addr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = DONE;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + ADDR_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      wcnt      <= '0;
      lat       <= '0;
      iter_cnt  <= 8'd0;
      llr_ready <= 1'b0;
      mem_init  <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_done  <= 1'b0;
      busy      <= 1'b0;
      dec_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      wcnt      <= wcnt_nxt;
      lat       <= lat_nxt;
      iter_cnt  <= iter_nxt;
      llr_ready <= (state_nxt == LOAD) && (wcnt_nxt != (ADDR_W+1)'(DEPTH));
      mem_init  <= init_nxt;
      mem_re    <= (state_nxt == READ);
      mem_we    <= (state_nxt == WRITE);
      mem_done  <= (state_nxt == FLUSH);
      busy      <= (state_nxt != IDLE);
      dec_done  <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mij_sched_ctrl.sv
// Scoreboard bench for mij_sched_ctrl: expected strobe events (kind, address, spacing)
// are queued per decode and popped by a monitor whenever a strobe or dec_done appears.
`timescale 1ns/1ps

module tb_mij_sched_ctrl;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int MAX_ITER = 8;
  localparam int PROC_LAT = 2;
`ifdef SYNDROME_EARLY_EXIT_EN
  localparam int EXP_B = 3;
`else
  localparam int EXP_B = MAX_ITER;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              llr_valid = 1'b0;
  logic              syndrome_ok = 1'b0;
  logic              llr_ready;
  logic              mem_init, mem_re, mem_we, mem_done;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        iter_cnt;
  logic              busy, dec_done;

  mij_sched_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_ITER(MAX_ITER), .PROC_LAT(PROC_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .llr_valid(llr_valid), .llr_ready(llr_ready),
    .syndrome_ok(syndrome_ok), .mem_init(mem_init), .mem_re(mem_re), .mem_we(mem_we),
    .mem_done(mem_done), .addr(addr), .iter_cnt(iter_cnt), .busy(busy), .dec_done(dec_done)
  );

  always #5 clk = ~clk;

  // kind: 0 init, 1 read, 2 write, 3 done strobe, 4 dec_done; gap -1 means unchecked
  typedef struct {
    int kind;
    int addr;
    int gap;
    int iter;
    int span;
    bit first;
  } ev_t;

  ev_t q[$];
  int  compared = 0;
  int  mismatched = 0;

  function automatic void push(int kind, int a, int gap, int iter, int span, bit first);
    ev_t e;
    e.kind = kind; e.addr = a; e.gap = gap; e.iter = iter; e.span = span; e.first = first;
    q.push_back(e);
  endfunction

  task automatic push_decode(input bit stall, input int n_iter);
    for (int k = 0; k < DEPTH; k++)
      push(0, k, (k == 0) ? -1 : ((stall && k == 6) ? 4 : 1), 0, 0, k == 0);
    for (int it = 0; it < n_iter; it++) begin
      for (int k = 0; k < DEPTH; k++) begin
        push(1, k, (k == 0) ? ((it == 0) ? 1 : 2) : 1, 0, 0, 1'b0);
        push(2, k, PROC_LAT + 1, 0, 0, 1'b0);
      end
    end
    for (int k = 0; k < DEPTH; k++)
      push(3, k, (k == 0) ? 2 : 1, 0, 0, 1'b0);
    push(4, 0, 1, n_iter,
         DEPTH + n_iter * (DEPTH * (PROC_LAT + 2) + 1) + DEPTH + (stall ? 3 : 0), 1'b0);
  endtask

  int  cyc = 0;
  int  last_cyc = 0;
  int  first_cyc = 0;
  bit  prev_done = 1'b0;
  int  m_n, m_kind;
  bit  m_ok;
  ev_t m_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        compared++;
        if (busy !== 1'b0) begin
          mismatched++;
          $display("FAIL busy_after_done: got %0b, want 0", busy);
        end
      end
      prev_done = dec_done;
      m_n = int'(mem_init) + int'(mem_re) + int'(mem_we) + int'(mem_done) + int'(dec_done);
      if (m_n != 0) begin
        m_kind = (m_n > 1) ? 7 : mem_init ? 0 : mem_re ? 1 : mem_we ? 2 : mem_done ? 3 : 4;
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event: got kind %0d addr %0d, want no event", m_kind, addr);
        end else begin
          m_e = q.pop_front();
          if (m_e.first) first_cyc = cyc;
          m_ok = (m_kind == m_e.kind) && (int'(addr) == m_e.addr) &&
                 (m_e.gap < 0 || (cyc - last_cyc) == m_e.gap);
          if (m_e.kind == 4)
            m_ok = m_ok && (int'(iter_cnt) == m_e.iter) && ((cyc - first_cyc) == m_e.span) && busy;
          if (!m_ok) begin
            mismatched++;
            $display("FAIL event: got kind %0d addr %0d gap %0d iter %0d span %0d busy %0b, want kind %0d addr %0d gap %0d iter %0d span %0d",
                     m_kind, addr, cyc - last_cyc, iter_cnt, cyc - first_cyc, busy,
                     m_e.kind, m_e.addr, m_e.gap, m_e.iter, m_e.span);
          end
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic int all_outputs();
    return int'({llr_ready, mem_init, mem_re, mem_we, mem_done, busy, dec_done, addr, iter_cnt});
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load(input bit stall);
    int k = 0;
    int st = 0;
    int guard = 0;
    bit prev_stall = 1'b0;
    while (llr_ready === 1'b1 && guard < 200) begin
      if (prev_stall) begin
        check("stall_addr", int'(addr), 6);
        check("stall_ready_noinit", int'({llr_ready, mem_init}), 2);
      end
      if (stall && k == 6 && st < 3) begin
        llr_valid = 1'b0;
        st++;
        prev_stall = 1'b1;
      end else begin
        llr_valid = 1'b1;
        k++;
        prev_stall = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    llr_valid = 1'b1;
    check("load_words", k, DEPTH);
  endtask

  task automatic wait_event(input string name, input int which, input int limit);
    int seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && dec_done) || (which == 1 && mem_done)) begin
        seen = 1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #1 rst = 1'b0;
    #3 check("reset_outputs", all_outputs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Decode A: llr_valid held, start pulsed again during FLUSH
    push_decode(1'b0, MAX_ITER);
    do_start();
    do_load(1'b0);
    wait_event("flush_seen", 1, 800);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_event("done_a", 0, 100);
    repeat (4) @(negedge clk);
    check("no_restart", int'({busy, llr_ready, mem_init}), 0);
    check("iter_hold", int'(iter_cnt), MAX_ITER);

    // Decode B: load stall after word 5, syndrome_ok in the CHECK of iteration 3
    push_decode(1'b1, EXP_B);
    do_start();
    do_load(1'b1);
    n = 0;
    for (int i = 0; i < 800 && n < 3; i++) begin
      @(negedge clk);
      if (mem_we && addr == ADDR_W'(DEPTH - 1)) n++;
    end
    check("we_last_seen", n, 3);
    @(negedge clk);
    check("iter_in_check", int'(iter_cnt), 2);
    syndrome_ok = 1'b1;
    @(negedge clk);
    syndrome_ok = 1'b0;
    wait_event("done_b", 0, 700);
    check("iter_final_b", int'(iter_cnt), EXP_B);

    // Decode C: reset asserted mid-iteration
    push_decode(1'b0, MAX_ITER);
    do_start();
    do_load(1'b0);
    repeat (85) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("reset_mid", all_outputs(), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;

    // Decode D: clean restart after reset
    push_decode(1'b0, MAX_ITER);
    do_start();
    do_load(1'b0);
    wait_event("done_d", 0, 700);
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mij_sched_ctrl.md
Name: mij_sched_ctrl

Overview:
- Sequencer for the M_ij message memory in the QC-LDPC decoder.
- Drives the memory's init, read, write and done strobes plus a shared word address.
- Runs one decode in four phases: LLR load, iterative read/process/write-back, hard-decision flush, done.
- Sits between the decoder top-level start/handshake and the M_ij instance; the node-processing datapath hangs off the read/write strobes.

Parameters:
DEPTH, 16, words per memory frame (power of two)
ADDR_W, 4, address width, log2(DEPTH)
MAX_ITER, 8, maximum decoding iterations (1..255)
PROC_LAT, 2, cycles from mem_re to mem_we for node processing (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  begin a decode; sampled only in IDLE
llr_valid  in  1  channel LLR word available
llr_ready  out  1  controller accepts LLR word (LOAD only)
syndrome_ok  in  1  parity check satisfied; sampled only in CHECK
mem_init  out  1  to M_ij data_initial
mem_re  out  1  to M_ij re
mem_we  out  1  to M_ij we
mem_done  out  1  to M_ij done
addr  out  ADDR_W  word address for the active strobe
iter_cnt  out  8  completed iterations of the current decode
busy  out  1  high in every state except IDLE
dec_done  out  1  one-cycle pulse at decode end

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All strobes, llr_ready, busy and dec_done are 0; addr=0; iter_cnt=0. Release is synchronous to clk.
- All outputs are registered. mem_init, mem_re, mem_we and mem_done are mutually exclusive (one-hot or all zero) in every cycle.
- IDLE: if start=1, go to LOAD next cycle with addr=0 and iter_cnt=0. In every other state, start is ignored.
- LOAD: llr_ready=1.
  - Each cycle with llr_valid=1: mem_init=1 at the current addr; addr increments.
  - llr_valid=0 stalls the phase: no strobe, addr holds.
  - After word DEPTH-1 is accepted: addr wraps to 0, go to READ.
- READ: mem_re=1 for 1 cycle at addr, then WAIT.
- WAIT: no strobe for PROC_LAT cycles (internal counter), then WRITE.
- WRITE: mem_we=1 for 1 cycle at the same addr.
  - If addr<DEPTH-1: addr increments, go to READ.
  - Else: addr wraps to 0, go to CHECK.
- Cost per word is PROC_LAT+2 cycles; per iteration DEPTH*(PROC_LAT+2) cycles, plus 1 cycle in CHECK.
- CHECK (1 cycle): iter_cnt increments (saturates at 255).
  - If the exit condition holds, go to FLUSH; else go to READ with addr=0.
  - The exit condition is iter_cnt+1==MAX_ITER, or the early-exit case described under Optional Feature.
- FLUSH: mem_done=1 for DEPTH consecutive cycles, addr 0..DEPTH-1, then DONE.
- DONE: dec_done=1 for 1 cycle; addr=0; go to IDLE. iter_cnt holds its final value until the next start.
- Reset asserted mid-decode: immediate return to reset values. No partial strobe may survive the reset edge.
- syndrome_ok and llr_valid have no effect outside their sampling states.

Optional Feature:
SYNDROME_EARLY_EXIT_EN
- Defined: in CHECK, syndrome_ok=1 also forces FLUSH, even when iter_cnt+1<MAX_ITER.
- Undefined: syndrome_ok is ignored and every decode runs exactly MAX_ITER iterations. The port remains present.

Test Plan:
- Defaults, llr_valid held 1, pulse start:
  - 16 consecutive mem_init cycles with addr 0..15.
  - dec_done occurs 552 cycles after the first LOAD cycle (16 + 8*65 + 16).
  - iter_cnt=8.
- LOAD stall: drop llr_valid for 3 cycles after word 5 -> addr holds 6, no mem_init, llr_ready stays 1; load completes 3 cycles later.
- Per-word timing in iteration 1 -> mem_re at addr=k, two idle cycles, mem_we at addr=k; pattern repeats with period 4; CHECK follows WRITE of addr 15.
- syndrome_ok=1 in the CHECK of iteration 3:
  - With SYNDROME_EARLY_EXIT_EN: FLUSH starts next cycle, final iter_cnt=3.
  - Without the macro: decode runs on to iter_cnt=8.
- Reset at cycle 100 (mid READ/WAIT) -> all outputs 0 combinationally after the rst fall; start after release begins a clean LOAD at addr 0.
- Pulse start during FLUSH -> ignored: no extra LOAD; a single dec_done pulse; busy falls in the cycle after dec_done.
